// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshakes and a 2-entry skid buffer.
// Carries one opaque payload. Downstream back-pressure is absorbed by the skid entry,
// so it never reaches upstream combinationally. Also provides a global stall/rdy freeze,
// a flush, and a saturating count of frozen occupied cycles.
module pipe_stage_skid #(
  parameter int unsigned        DATA_W     = 112,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter int unsigned        STALL_W    = 3,
  parameter logic [STALL_W-1:0] STALL_MASK = STALL_W'(3'b110),
  parameter int unsigned        CNT_W      = 16
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               main_valid_q, main_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic hold;
  logic accept;
  logic drain;

  // Freeze condition: any masked stall bit or global not-ready.
  assign hold = (|(stall & STALL_MASK)) | ~rdy_in;

  // Upstream ready depends only on local state and global controls, never on out_ready.
  assign in_ready = rst_n_in & ~skid_valid_q & ~hold & ~flush;

  assign accept = in_valid & in_ready;
  assign drain  = main_valid_q & out_ready & ~hold;

  // Next-state, data movement and stall counter.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    cnt_d       = cnt_q;

    // Count frozen cycles only while an instruction is held; saturate at all-ones.
    if (hold && main_valid_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush) begin
      state_d     = ST_EMPTY;
      main_data_d = BUBBLE_VAL;
      skid_data_d = BUBBLE_VAL;
    end else if (!hold) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
          end else if (drain) begin
            state_d     = ST_EMPTY;
            main_data_d = BUBBLE_VAL;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            skid_data_d = BUBBLE_VAL;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_data_d = BUBBLE_VAL;
          skid_data_d = BUBBLE_VAL;
        end
      endcase
    end

    main_valid_d = (state_d != ST_EMPTY);
    skid_valid_d = (state_d == ST_TWO);
    occ_d        = OCC_W'(main_valid_d) + OCC_W'(skid_valid_d);
  end

  // State and payload registers; reset discards all entries and clears the counter.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= BUBBLE_VAL;
      skid_data_q  <= BUBBLE_VAL;
      occ_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      occ_q        <= occ_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_data     = main_data_q;
  assign occupancy    = occ_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with a queue-based reference of held entries.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned STALL_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam logic [DATA_W-1:0] BUB = 16'h0013;
  localparam logic [STALL_W-1:0] MASK = 3'b110;
  localparam int CNT_MAX = 15;

  logic               clk_in = 1'b0;
  logic               rst_n_in;
  logic               rdy_in;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: entries held by the stage, oldest first (scoreboard of pending outputs).
  logic [DATA_W-1:0] mq[$];
  int exp_cnt = 0;

  pipe_stage_skid #(
    .DATA_W(DATA_W), .BUBBLE_VAL(BUB), .STALL_W(STALL_W),
    .STALL_MASK(MASK), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .stall(stall),
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic [2:0] stl,
                       input logic fl, input logic iv, input logic [15:0] id,
                       input logic ordy);
    rst_n_in  = rst;
    rdy_in    = rdy;
    stall     = stl;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
  endtask

  // Check outputs against the reference, then advance reference and DUT by one edge.
  task automatic tick(input bit do_chk);
    logic hold_b;
    logic exp_rdy;
    logic acc;
    logic drn;
    logic [DATA_W-1:0] popped;
    #1;
    hold_b  = (|(stall & MASK)) || !rdy_in;
    exp_rdy = rst_n_in && (mq.size() < 2) && !hold_b && !flush;
    if (do_chk) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      chk("out_data", {16'd0, out_data}, {16'd0, (mq.size() > 0) ? mq[0] : BUB});
      chk("occupancy", {30'd0, occupancy}, 32'(mq.size()));
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("stall_cycles", {28'd0, stall_cycles}, 32'(exp_cnt));
    end
    if (!rst_n_in) begin
      mq.delete();
      exp_cnt = 0;
    end else begin
      if (hold_b && mq.size() > 0 && exp_cnt < CNT_MAX) exp_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        drn = (mq.size() > 0) && out_ready && !hold_b;
        acc = in_valid && exp_rdy;
        if (drn) begin
          popped = mq.pop_front();
          if (do_chk) chk("drain_data", {16'd0, out_data}, {16'd0, popped});
        end
        if (acc) mq.push_back(in_data);
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    drive(0, 1, 3'b000, 0, 0, 16'h0, 1);
    @(negedge clk_in);
    tick(0);
    tick(1);

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 3'b000, 0, 1, 16'(i), 1);
      tick(1);
      chk("stream_occ", {30'd0, occupancy}, 32'd1);
      chk("stream_out", {16'd0, out_data}, 32'(i));
    end
    drive(1, 1, 3'b000, 0, 0, 16'h0, 1);
    tick(1);
    tick(1);

    // Back-pressure into the skid entry.
    drive(1, 1, 3'b000, 0, 1, 16'h000A, 1); tick(1);
    drive(1, 1, 3'b000, 0, 1, 16'h000B, 0); tick(1);
    drive(1, 1, 3'b000, 0, 1, 16'h000C, 0); tick(1);
    tick(1);
    #1;
    chk("bp_occ", {30'd0, occupancy}, 32'd2);
    chk("bp_main", {16'd0, out_data}, 32'h000A);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1, 1, 3'b000, 0, 1, 16'h000C, 1); tick(1);
    chk("bp_out_b", {16'd0, out_data}, 32'h000B);
    tick(1);
    chk("bp_out_c", {16'd0, out_data}, 32'h000C);
    drive(1, 1, 3'b000, 0, 0, 16'h0, 1); tick(1);
    tick(1);

    // Stall freeze, unmasked stall bit, rdy_in freeze.
    drive(0, 1, 3'b000, 0, 0, 16'h0, 1); tick(1);
    drive(1, 1, 3'b000, 0, 1, 16'h0055, 0); tick(1);
    drive(1, 1, 3'b010, 0, 1, 16'h0066, 1);
    for (int i = 0; i < 5; i++) tick(1);
    chk("stall5_cnt", {28'd0, stall_cycles}, 32'd5);
    chk("stall5_data", {16'd0, out_data}, 32'h0055);
    drive(1, 1, 3'b001, 0, 0, 16'h0, 0); tick(1);
    chk("unmasked_cnt", {28'd0, stall_cycles}, 32'd5);
    drive(1, 0, 3'b000, 0, 0, 16'h0, 1);
    for (int i = 0; i < 3; i++) tick(1);
    chk("rdy8_cnt", {28'd0, stall_cycles}, 32'd8);
    drive(1, 1, 3'b000, 0, 0, 16'h0, 1); tick(1);
    tick(1);

    // Flush with two entries held, plain and under hold.
    drive(1, 1, 3'b000, 0, 1, 16'h00D1, 0); tick(1);
    drive(1, 1, 3'b000, 0, 1, 16'h00D2, 0); tick(1);
    drive(1, 1, 3'b000, 1, 1, 16'h0077, 1); tick(1);
    chk("flush_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_data", {16'd0, out_data}, {16'd0, BUB});
    drive(1, 1, 3'b000, 0, 0, 16'h0, 1); tick(1);
    drive(1, 1, 3'b000, 0, 1, 16'h00E1, 0); tick(1);
    drive(1, 1, 3'b000, 0, 1, 16'h00E2, 0); tick(1);
    drive(1, 1, 3'b010, 1, 1, 16'h0078, 1); tick(1);
    chk("flush_hold_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_hold_data", {16'd0, out_data}, {16'd0, BUB});
    drive(1, 1, 3'b000, 0, 0, 16'h0, 1); tick(1);

    // Reset mid-operation with two entries and a non-zero counter.
    drive(0, 1, 3'b000, 0, 0, 16'h0, 1); tick(1);
    drive(1, 1, 3'b000, 0, 1, 16'h00F1, 0); tick(1);
    drive(1, 1, 3'b000, 0, 1, 16'h00F2, 0); tick(1);
    drive(1, 0, 3'b000, 0, 1, 16'h00F3, 0);
    for (int i = 0; i < 7; i++) tick(1);
    chk("pre_rst_cnt", {28'd0, stall_cycles}, 32'd7);
    chk("pre_rst_occ", {30'd0, occupancy}, 32'd2);
    drive(0, 0, 3'b010, 1, 1, 16'h00F4, 1); tick(1);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {16'd0, out_data}, {16'd0, BUB});
    chk("rst_cnt", {28'd0, stall_cycles}, 32'd0);

    // Counter saturation.
    drive(1, 1, 3'b000, 0, 1, 16'h0099, 0); tick(1);
    drive(1, 0, 3'b000, 0, 0, 16'h0, 0);
    for (int i = 0; i < 20; i++) tick(1);
    chk("sat_cnt", {28'd0, stall_cycles}, 32'h0000000F);
    drive(1, 1, 3'b000, 0, 0, 16'h0, 1); tick(1);
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload of DATA_W bits between two stages using valid/ready handshakes and a 2-entry skid buffer, so a downstream back-pressure does not combinationally reach upstream.
- Keeps the existing global stall-vector, rdy_in gating and bubble-on-reset semantics.
- Adds flush, back-pressure and a saturating stall-cycle counter.

Parameters:
- DATA_W, 112, payload width in bits (forward + rd_addr + rd_val + ins_type + ins_details + mem_addr + mem_val).
- BUBBLE_VAL, {DATA_W{1'b0}}, payload driven when the stage holds no instruction (NOP/ADDI encoding supplied by the instantiator).
- STALL_W, 3, width of the global stall vector.
- STALL_MASK, 3'b110, stall bits that freeze this stage.
- CNT_W, 16, stall counter width.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  synchronous active-low reset.
- rdy_in  input  1  global ready; 0 freezes the stage exactly as a masked stall does.
- stall  input  STALL_W  global stall vector.
- flush  input  1  discard all held entries (branch mispredict).
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a live instruction.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  DATA_W  payload to downstream.
- occupancy  output  2  number of held entries (0..2).
- stall_cycles  output  CNT_W  saturating count of frozen cycles while occupied.

Behaviour:
- hold = |(stall & STALL_MASK) | !rdy_in (combinational).
- Internal state:
  - main register (main_valid, main_data) drives out_valid/out_data directly.
  - skid register (skid_valid, skid_data).
  - States: EMPTY (no entries), ONE (main only), TWO (main and skid).
  - occupancy = main_valid + skid_valid.
- Handshake signals:
  - in_ready = !skid_valid & !hold & !flush.
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready & !hold.
- Transitions (apply only when rst_n_in=1 and flush=0):
  - EMPTY: accept -> ONE, main<=in_data. Otherwise stay EMPTY.
  - ONE: accept & drain -> ONE, main<=in_data.
  - ONE: accept & !drain -> TWO, skid<=in_data.
  - ONE: !accept & drain -> EMPTY, main_data<=BUBBLE_VAL.
  - ONE: otherwise stay ONE.
  - TWO: drain -> ONE, main<=skid_data, skid_data<=BUBBLE_VAL. Otherwise stay TWO. No accept is possible in TWO.
- hold=1: no state or data change at all; in_ready=0. out_valid/out_data stay stable, and the downstream must ignore out_ready.
- Ordering is FIFO: skid contents always follow main.
- Latency: 1 cycle from accept to out_valid when the stage was EMPTY (or ONE with a simultaneous drain). Full throughput of 1 payload per cycle with out_ready held at 1.
- Flush:
  - Takes priority over hold and over handshakes.
  - Next cycle: main_valid=skid_valid=0, both data registers = BUBBLE_VAL.
  - in_ready=0 during flush, so any offered input is not accepted.
  - stall_cycles is unaffected by flush.
- Reset (rst_n_in=0, sampled at the clock edge):
  - Reset values: out_valid=0, out_data=BUBBLE_VAL, skid cleared to BUBBLE_VAL, occupancy=0, stall_cycles=0.
  - in_ready is driven 0 during the reset cycle.
  - Reset overrides flush and hold.
  - Reset mid-operation discards all entries.
- stall_cycles:
  - Increments by 1 each cycle with hold & main_valid & rst_n_in.
  - Saturates at all-ones with no wrap.
  - Cleared only by reset.
- Outputs are purely registered, except in_ready, which is combinational from hold, flush and skid_valid only, with no path from out_ready.

Test Plan:
- Streaming: reset, then in_valid=1 with payloads 0x1..0x8 on consecutive cycles, out_ready=1, no stall -> out_data 0x1..0x8 one cycle later each, occupancy never above 1, in_ready always 1.
- Back-pressure: stream 0xA,0xB,0xC with out_ready=0 from the second cycle -> main=0xA, skid=0xB, in_ready=0, occupancy=2, 0xC held off upstream. Then out_ready=1 -> out_data 0xA, 0xB, 0xC in order, with no loss or duplication.
- Stall: stall=3'b010 for 5 cycles while holding 0x55 -> out_data stays 0x55, in_ready=0, stall_cycles=5. stall=3'b001 (unmasked) -> no freeze. rdy_in=0 for 3 cycles -> stall_cycles=8.
- Flush: occupancy=2 with a simultaneous in_valid and flush=1 (also with hold=1) -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VAL, and the offered input is not accepted.
- Reset: rst_n_in=0 for one cycle mid-stream with occupancy=2 and stall_cycles=7 -> all outputs at their reset values. With CNT_W=4 and hold forced for 20 occupied cycles -> stall_cycles saturates at 0xF.
